// File: rtl/urna_pkg.sv
// urna_pkg: shared session states and the default session length
package urna_pkg;
  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    ABIERTA = 2'd1,
    CERRADA = 2'd2
  } estado_t;
  localparam int TIMEOUT_DEF = 1000;
endpackage

// File: rtl/temporizador.sv
// temporizador: saturating session-length counter, fin marks the last open cycle
module temporizador import urna_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic fin
);
  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] ULTIMO = W'(TIMEOUT - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && cnt != ULTIMO) cnt <= cnt + W'(1);
  assign fin = cnt == ULTIMO;
endmodule

// File: rtl/urna.sv
// urna: three-voter ballot box with one vote per voter and a session timeout
module urna import urna_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       abrir,
  input  logic [2:0] pulsa,
  input  logic [2:0] voto,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] votado,
  output logic       abierta,
  output logic       listo,
  output logic       expirado
);
  estado_t estado, siguiente;
  logic fin, abrir_ses, completo;
  logic [2:0] captura, votado_n;
  temporizador #(.TIMEOUT(TIMEOUT)) u_temporizador (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (abrir_ses),
    .enable (estado == ABIERTA),
    .fin    (fin)
  );
  always_comb begin
    captura   = estado == ABIERTA ? pulsa & ~votado : 3'b000;
    votado_n  = votado | captura;
    completo  = &votado_n;
    abrir_ses = abrir && estado != ABIERTA;
    siguiente = estado == ABIERTA ? ((completo || fin) ? CERRADA : ABIERTA)
                                  : (abrir ? ABIERTA : estado);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) estado <= ESPERA;
    else estado <= siguiente;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {a, b, c, votado, abierta, listo, expirado} <= '0;
    end else begin
      abierta <= siguiente == ABIERTA;
      listo   <= siguiente == CERRADA;
      if (abrir_ses) begin
        {a, b, c} <= 3'b000;
        votado    <= 3'b000;
        expirado  <= 1'b0;
      end else if (estado == ABIERTA) begin
        a        <= a | (captura[0] & voto[0]);
        b        <= b | (captura[1] & voto[1]);
        c        <= c | (captura[2] & voto[2]);
        votado   <= votado_n;
        expirado <= fin && !completo;
      end
    end
endmodule

// File: tb/tb_urna.sv
// tb_urna: random and directed sessions on two urna instances against a session-level model
module tb_urna;
  localparam int TO [2] = '{8, 4};
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic abrir = 1'b0;
  logic [2:0] pulsa = 3'b000;
  logic [2:0] voto = 3'b000;
  logic [1:0] a, b, c, abierta, listo, expirado;
  logic [2:0] votado [2];
  logic mayoria;
  int checks = 0;
  int errors = 0;
  bit m_open [2];
  bit m_closed [2];
  bit m_exp [2];
  int m_cnt [2];
  logic [2:0] m_has [2];
  logic [2:0] m_v [2];
  urna #(.TIMEOUT(8)) u8 (
    .clk(clk), .reset_n(reset_n), .abrir(abrir), .pulsa(pulsa), .voto(voto),
    .a(a[0]), .b(b[0]), .c(c[0]), .votado(votado[0]),
    .abierta(abierta[0]), .listo(listo[0]), .expirado(expirado[0])
  );
  urna #(.TIMEOUT(4)) u4 (
    .clk(clk), .reset_n(reset_n), .abrir(abrir), .pulsa(pulsa), .voto(voto),
    .a(a[1]), .b(b[1]), .c(c[1]), .votado(votado[1]),
    .abierta(abierta[1]), .listo(listo[1]), .expirado(expirado[1])
  );
  assign mayoria = (a[0] & b[0]) | (a[0] & c[0]) | (b[0] & c[0]);
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask
  function automatic logic [31:0] seen(input int k);
    return 32'({abierta[k], listo[k], expirado[k], votado[k], a[k], b[k], c[k]});
  endfunction
  function automatic logic [31:0] want(input int k);
    return 32'({m_open[k], m_closed[k], m_exp[k], m_has[k], m_v[k][0], m_v[k][1], m_v[k][2]});
  endfunction
  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_open[k] = 0;
      m_closed[k] = 0;
      m_exp[k] = 0;
      m_cnt[k] = 0;
      m_has[k] = 3'b000;
      m_v[k] = 3'b000;
    end
  endtask
  task automatic m_step(input int k);
    if (!m_open[k]) begin
      if (abrir) begin
        m_open[k] = 1;
        m_closed[k] = 0;
        m_exp[k] = 0;
        m_cnt[k] = 0;
        m_has[k] = 3'b000;
        m_v[k] = 3'b000;
      end
    end else begin
      for (int i = 0; i < 3; i++)
        if (pulsa[i] && !m_has[k][i]) begin
          m_has[k][i] = 1'b1;
          m_v[k][i] = voto[i];
        end
      if (m_has[k] == 3'b111) begin
        m_open[k] = 0;
        m_closed[k] = 1;
      end else if (m_cnt[k] == TO[k] - 1) begin
        m_open[k] = 0;
        m_closed[k] = 1;
        m_exp[k] = 1;
      end else begin
        m_cnt[k]++;
      end
    end
  endtask
  task automatic ciclo(input logic ab, input logic [2:0] pu, input logic [2:0] vo);
    abrir = ab;
    pulsa = pu;
    voto = vo;
    @(posedge clk);
    m_step(0);
    m_step(1);
    @(negedge clk);
    check("ciclo_t8", seen(0), want(0));
    check("ciclo_t4", seen(1), want(1));
  endtask
  task automatic pulso_reset();
    #1 reset_n = 1'b0;
    #1 m_reset();
    check("rst_async_t8", seen(0), 32'd0);
    check("rst_async_t4", seen(1), 32'd0);
    #1 reset_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
  initial begin
    m_reset();
    @(negedge clk);
    check("reset_t8", seen(0), 32'd0);
    check("reset_t4", seen(1), 32'd0);
    reset_n = 1'b1;
    ciclo(1'b1, 3'b000, 3'b000);
    ciclo(1'b0, 3'b001, 3'b001);
    ciclo(1'b0, 3'b010, 3'b010);
    ciclo(1'b0, 3'b100, 3'b000);
    check("tres_votos", 32'({listo[0], a[0], b[0], c[0], expirado[0]}), 32'b11100);
    pulso_reset();
    ciclo(1'b1, 3'b000, 3'b000);
    ciclo(1'b0, 3'b001, 3'b001);
    repeat (6) ciclo(1'b0, 3'b000, 3'b000);
    check("abierta_7", 32'(abierta[0]), 32'd1);
    ciclo(1'b0, 3'b000, 3'b000);
    check("timeout_8", 32'({listo[0], expirado[0], votado[0], a[0], b[0], c[0]}), 32'b11_001_100);
    pulso_reset();
    ciclo(1'b1, 3'b000, 3'b000);
    ciclo(1'b0, 3'b001, 3'b001);
    ciclo(1'b0, 3'b001, 3'b000);
    check("sin_sobrescribir", 32'({a[0], votado[0][0]}), 32'b11);
    pulso_reset();
    ciclo(1'b1, 3'b000, 3'b000);
    ciclo(1'b0, 3'b001, 3'b001);
    ciclo(1'b0, 3'b010, 3'b010);
    ciclo(1'b0, 3'b000, 3'b000);
    ciclo(1'b0, 3'b100, 3'b100);
    check("empate_t4", 32'({listo[1], expirado[1], votado[1]}), 32'b10_111);
    ciclo(1'b1, 3'b000, 3'b000);
    ciclo(1'b0, 3'b011, 3'b011);
    pulso_reset();
    ciclo(1'b1, 3'b000, 3'b000);
    check("votado_tras_rst", 32'(votado[0]), 32'd0);
    for (int v = 0; v < 8; v++) begin
      pulso_reset();
      ciclo(1'b1, 3'b000, 3'b000);
      ciclo(1'b0, 3'b111, 3'(v));
      check("listo_mayoria", 32'(listo[0]), 32'd1);
      check("mayoria", 32'(mayoria), 32'($countones(3'(v)) >= 2));
    end
    repeat (600) begin
      if ($urandom_range(0, 150) == 0) pulso_reset();
      else ciclo($urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0 ? 3'($urandom) : 3'b000,
                 3'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/urna.md
URNA -- requirements
Module: urna

Interface
REQ-001 Parameter TIMEOUT, default 1000, session length in clk cycles from opening to forced close; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 abrir  input  1  open-session request, sampled each cycle.
REQ-005 pulsa  input  3  per-voter cast strobe; bit 0 = voter a, bit 1 = voter b, bit 2 = voter c.
REQ-006 voto  input  3  per-voter vote value (1 = yes), sampled with the matching pulsa bit.
REQ-007 a, b, c  output  1 each  registered votes; these feed the downstream majority voter directly.
REQ-008 votado  output  3  per-voter "has cast" flags, same bit order as pulsa.
REQ-009 abierta  output  1  session open.
REQ-010 listo  output  1  session closed; a, b, c final and valid.
REQ-011 expirado  output  1  session closed by timeout rather than by the third vote.

Function
REQ-012 The FSM SHALL have exactly three states: ESPERA (idle), ABIERTA (collecting votes), CERRADA (result held).
REQ-013 ESPERA: a, b, c, votado, abierta, listo and expirado are 0; abrir=1 -> ABIERTA on the next edge.
REQ-014 Entering ABIERTA from any state clears a, b, c, votado, expirado and the timeout counter in the same edge.
REQ-015 ABIERTA: pulsa[i]=1 with votado[i]=0 latches voto[i] into the vote register and sets votado[i] on that edge.
REQ-016 ABIERTA: pulsa[i]=1 with votado[i]=1 is ignored; one vote per voter per session, no overwrite.
REQ-017 Simultaneous strobes from several voters in one cycle are all captured.
REQ-018 ABIERTA: abrir is ignored.
REQ-019 Timeout counter: width = ceil(log2(TIMEOUT)), increments every ABIERTA cycle, never wraps.
REQ-020 ABIERTA -> CERRADA on the edge where the third vote is captured; listo=1 from that edge on, expirado=0.
REQ-021 ABIERTA -> CERRADA with expirado=1 on the edge where the counter equals TIMEOUT-1 and at least one vote is missing.
REQ-022 On timeout, missing votes remain 0 (abstention counts as "no").
REQ-023 If the last vote and the timeout fall in the same cycle, the vote is captured and expirado=0 (completion wins).
REQ-024 CERRADA: a, b, c, votado and expirado held; pulsa ignored; abrir=1 -> ABIERTA per REQ-014.
REQ-025 abierta=1 exactly while in ABIERTA; listo=1 exactly while in CERRADA.
REQ-026 All outputs SHALL be register outputs; no combinational path from inputs to outputs.

Reset
REQ-027 reset_n=0 SHALL immediately force ESPERA, clear all outputs, and clear the counter and vote registers, regardless of clk.
REQ-028 Reset asserted mid-session discards all captured votes; no listo pulse is produced.
REQ-029 After reset_n rises, the first abrir is honoured at the next rising edge.

Structure
REQ-030 State encodings (ESPERA=0, ABIERTA=1, CERRADA=2) and the default TIMEOUT SHALL live in the shared package urna_pkg.
REQ-031 The timeout counter SHALL be a sub-module temporizador (ports: clk, reset_n, clear, enable, fin), parameterised by TIMEOUT.
REQ-032 Vote capture and the FSM remain in urna; target size is 120-250 lines of RTL.

Verification
REQ-033 Reset, abrir=1; pulsa=001/voto=001, then 010/010, then 100/000 on separate cycles -> listo=1 one edge after the third strobe, a=1, b=1, c=0, expirado=0.
REQ-034 TIMEOUT=8, open, cast a only with voto=1 -> CERRADA after exactly 8 ABIERTA cycles, expirado=1, votado=001, a=1, b=0, c=0.
REQ-035 Open; voter a casts voto=1, then casts again with voto=0 -> a stays 1 and votado[0] stays 1.
REQ-036 TIMEOUT=4, third vote strobed on the 4th ABIERTA cycle -> vote captured, expirado=0, votado=111.
REQ-037 Reset_n pulsed low between clock edges mid-session -> outputs go 0 immediately; a later session starts with votado=000.
REQ-038 Bench connects a, b, c to the downstream majority voter and checks its output against the majority of the captured votes for all 8 vote combinations.
